// File: rtl/vxe_biu_client_mux_pkg.sv
// Shared definitions for the two-client BIU request mux.
// CID split helpers and request FIFO entry widths.
package vxe_biu_client_mux_pkg;

    // Bit position of the client index inside a BIU CID.
    function automatic int client_bit(input int cid_w);
        return cid_w - 1;
    endfunction

    // Width of the client-local CID.
    function automatic int local_cid_w(input int cid_w);
        return cid_w - 1;
    endfunction

    // Write request entry: CID + ADDR + DATA + STRB.
    function automatic int aw_entry_w(input int cid_w, input int addr_w,
                                      input int data_w);
        return cid_w + addr_w + data_w + data_w / 8;
    endfunction

    // Read request entry: CID + ADDR.
    function automatic int ar_entry_w(input int cid_w, input int addr_w);
        return cid_w + addr_w;
    endfunction

endpackage

// File: rtl/vxe_sync_fifo.sv
// Synchronous FIFO, 2**DEPTH_LOG2 entries, head shown combinationally.
// Ports: push/din in, pop in, dout head, full/empty flags.
module vxe_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    import vxe_biu_client_mux_pkg::*;

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    // Extra pointer MSB distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign dout = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/vxe_biu_client_mux.sv
// Two-client request mux in front of the AXI4 master BIU.
// Ports: c0_/c1_ aw/ar requests, b/r responses; biu_ FIFO heads and pushes.
module vxe_biu_client_mux
    import vxe_biu_client_mux_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CID_WIDTH  = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    c0_awvalid,
    output logic                    c0_awready,
    input  logic [CID_WIDTH-2:0]    c0_awcid,
    input  logic [ADDR_WIDTH-1:0]   c0_awaddr,
    input  logic [DATA_WIDTH-1:0]   c0_awdata,
    input  logic [DATA_WIDTH/8-1:0] c0_awstrb,
    input  logic                    c0_arvalid,
    output logic                    c0_arready,
    input  logic [CID_WIDTH-2:0]    c0_arcid,
    input  logic [ADDR_WIDTH-1:0]   c0_araddr,
    output logic                    c0_bvalid,
    input  logic                    c0_bready,
    output logic [CID_WIDTH-2:0]    c0_bcid,
    output logic [1:0]              c0_bresp,
    output logic                    c0_rvalid,
    input  logic                    c0_rready,
    output logic [CID_WIDTH-2:0]    c0_rcid,
    output logic [DATA_WIDTH-1:0]   c0_rdata,
    output logic [1:0]              c0_rresp,
    input  logic                    c1_awvalid,
    output logic                    c1_awready,
    input  logic [CID_WIDTH-2:0]    c1_awcid,
    input  logic [ADDR_WIDTH-1:0]   c1_awaddr,
    input  logic [DATA_WIDTH-1:0]   c1_awdata,
    input  logic [DATA_WIDTH/8-1:0] c1_awstrb,
    input  logic                    c1_arvalid,
    output logic                    c1_arready,
    input  logic [CID_WIDTH-2:0]    c1_arcid,
    input  logic [ADDR_WIDTH-1:0]   c1_araddr,
    output logic                    c1_bvalid,
    input  logic                    c1_bready,
    output logic [CID_WIDTH-2:0]    c1_bcid,
    output logic [1:0]              c1_bresp,
    output logic                    c1_rvalid,
    input  logic                    c1_rready,
    output logic [CID_WIDTH-2:0]    c1_rcid,
    output logic [DATA_WIDTH-1:0]   c1_rdata,
    output logic [1:0]              c1_rresp,
    output logic [CID_WIDTH-1:0]    biu_awcid,
    output logic [ADDR_WIDTH-1:0]   biu_awaddr,
    output logic [DATA_WIDTH-1:0]   biu_awdata,
    output logic [DATA_WIDTH/8-1:0] biu_awstrb,
    output logic                    biu_awvalid,
    input  logic                    biu_awpop,
    input  logic [CID_WIDTH-1:0]    biu_bcid,
    input  logic [1:0]              biu_bresp,
    output logic                    biu_bready,
    input  logic                    biu_bpush,
    output logic [CID_WIDTH-1:0]    biu_arcid,
    output logic [ADDR_WIDTH-1:0]   biu_araddr,
    output logic                    biu_arvalid,
    input  logic                    biu_arpop,
    input  logic [CID_WIDTH-1:0]    biu_rcid,
    input  logic [DATA_WIDTH-1:0]   biu_rdata,
    input  logic [1:0]              biu_rresp,
    output logic                    biu_rready,
    input  logic                    biu_rpush
);

    localparam int CB  = client_bit(CID_WIDTH);
    localparam int LW  = local_cid_w(CID_WIDTH);
    localparam int AWW = aw_entry_w(CID_WIDTH, ADDR_WIDTH, DATA_WIDTH);
    localparam int ARW = ar_entry_w(CID_WIDTH, ADDR_WIDTH);

    // ---------------- write request path ----------------
    logic           aw_ptr;
    logic           aw_sel;
    logic           aw_gnt;
    logic           aw_full;
    logic           aw_empty;
    logic [AWW-1:0] aw_din;
    logic [AWW-1:0] aw_dout;

    // sel = granted client: the lone requester, else the pointer.
    assign aw_sel = (c1_awvalid & ~c0_awvalid) |
                    (c1_awvalid & c0_awvalid & aw_ptr);
    assign aw_gnt = (c0_awvalid | c1_awvalid) & ~aw_full;

    assign c0_awready = aw_gnt & ~aw_sel;
    assign c1_awready = aw_gnt & aw_sel;

    assign aw_din = aw_sel ?
        {1'b1, c1_awcid, c1_awaddr, c1_awdata, c1_awstrb} :
        {1'b0, c0_awcid, c0_awaddr, c0_awdata, c0_awstrb};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)       aw_ptr <= 1'b0;
        else if (aw_gnt) aw_ptr <= ~aw_sel;
    end

    vxe_sync_fifo #(
        .WIDTH      (AWW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_aw_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (aw_gnt),
        .din   (aw_din),
        .pop   (biu_awpop),
        .dout  (aw_dout),
        .full  (aw_full),
        .empty (aw_empty)
    );

    assign biu_awvalid = ~aw_empty;
    assign {biu_awcid, biu_awaddr, biu_awdata, biu_awstrb} = aw_dout;

    // ---------------- read request path ----------------
    logic           ar_ptr;
    logic           ar_sel;
    logic           ar_gnt;
    logic           ar_full;
    logic           ar_empty;
    logic [ARW-1:0] ar_din;
    logic [ARW-1:0] ar_dout;

    assign ar_sel = (c1_arvalid & ~c0_arvalid) |
                    (c1_arvalid & c0_arvalid & ar_ptr);
    assign ar_gnt = (c0_arvalid | c1_arvalid) & ~ar_full;

    assign c0_arready = ar_gnt & ~ar_sel;
    assign c1_arready = ar_gnt & ar_sel;

    assign ar_din = ar_sel ? {1'b1, c1_arcid, c1_araddr} :
                             {1'b0, c0_arcid, c0_araddr};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)       ar_ptr <= 1'b0;
        else if (ar_gnt) ar_ptr <= ~ar_sel;
    end

    vxe_sync_fifo #(
        .WIDTH      (ARW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ar_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (ar_gnt),
        .din   (ar_din),
        .pop   (biu_arpop),
        .dout  (ar_dout),
        .full  (ar_full),
        .empty (ar_empty)
    );

    assign biu_arvalid = ~ar_empty;
    assign {biu_arcid, biu_araddr} = ar_dout;

    // ---------------- write response hold ----------------
    logic                 b_v;
    logic [CID_WIDTH-1:0] b_cid;
    logic [1:0]           b_resp;
    logic                 b_sel;
    logic                 b_cready;

    assign b_sel      = b_cid[CB];
    assign b_cready   = b_sel ? c1_bready : c0_bready;
    assign biu_bready = ~b_v | b_cready;

    assign c0_bvalid = b_v & ~b_sel;
    assign c1_bvalid = b_v & b_sel;
    assign c0_bcid   = b_cid[LW-1:0];
    assign c1_bcid   = b_cid[LW-1:0];
    assign c0_bresp  = b_resp;
    assign c1_bresp  = b_resp;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            b_v    <= 1'b0;
            b_cid  <= '0;
            b_resp <= '0;
        end else if (biu_bpush & biu_bready) begin
            b_v    <= 1'b1;
            b_cid  <= biu_bcid;
            b_resp <= biu_bresp;
        end else if (b_v & b_cready) begin
            b_v <= 1'b0;
        end
    end

    // ---------------- read response hold ----------------
    logic                  r_v;
    logic [CID_WIDTH-1:0]  r_cid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_sel;
    logic                  r_cready;

    assign r_sel      = r_cid[CB];
    assign r_cready   = r_sel ? c1_rready : c0_rready;
    assign biu_rready = ~r_v | r_cready;

    assign c0_rvalid = r_v & ~r_sel;
    assign c1_rvalid = r_v & r_sel;
    assign c0_rcid   = r_cid[LW-1:0];
    assign c1_rcid   = r_cid[LW-1:0];
    assign c0_rdata  = r_data;
    assign c1_rdata  = r_data;
    assign c0_rresp  = r_resp;
    assign c1_rresp  = r_resp;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_v    <= 1'b0;
            r_cid  <= '0;
            r_data <= '0;
            r_resp <= '0;
        end else if (biu_rpush & biu_rready) begin
            r_v    <= 1'b1;
            r_cid  <= biu_rcid;
            r_data <= biu_rdata;
            r_resp <= biu_rresp;
        end else if (r_v & r_cready) begin
            r_v <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vxe_biu_client_mux.sv
// Bench for vxe_biu_client_mux: directed scenarios plus random traffic.
// A queue-based reference model predicts every output each cycle.
module tb_vxe_biu_client_mux;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int LW = 7;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    logic          c0_awvalid, c0_awready, c1_awvalid, c1_awready;
    logic [LW-1:0] c0_awcid, c1_awcid;
    logic [AW-1:0] c0_awaddr, c1_awaddr;
    logic [DW-1:0] c0_awdata, c1_awdata;
    logic [SW-1:0] c0_awstrb, c1_awstrb;
    logic          c0_arvalid, c0_arready, c1_arvalid, c1_arready;
    logic [LW-1:0] c0_arcid, c1_arcid;
    logic [AW-1:0] c0_araddr, c1_araddr;
    logic          c0_bvalid, c0_bready, c1_bvalid, c1_bready;
    logic [LW-1:0] c0_bcid, c1_bcid;
    logic [1:0]    c0_bresp, c1_bresp;
    logic          c0_rvalid, c0_rready, c1_rvalid, c1_rready;
    logic [LW-1:0] c0_rcid, c1_rcid;
    logic [DW-1:0] c0_rdata, c1_rdata;
    logic [1:0]    c0_rresp, c1_rresp;
    logic [CW-1:0] biu_awcid, biu_arcid, biu_bcid, biu_rcid;
    logic [AW-1:0] biu_awaddr, biu_araddr;
    logic [DW-1:0] biu_awdata, biu_rdata;
    logic [SW-1:0] biu_awstrb;
    logic          biu_awvalid, biu_awpop, biu_arvalid, biu_arpop;
    logic [1:0]    biu_bresp, biu_rresp;
    logic          biu_bready, biu_bpush, biu_rready, biu_rpush;

    vxe_biu_client_mux dut (
        .clk(clk), .nrst(nrst),
        .c0_awvalid(c0_awvalid), .c0_awready(c0_awready),
        .c0_awcid(c0_awcid), .c0_awaddr(c0_awaddr),
        .c0_awdata(c0_awdata), .c0_awstrb(c0_awstrb),
        .c0_arvalid(c0_arvalid), .c0_arready(c0_arready),
        .c0_arcid(c0_arcid), .c0_araddr(c0_araddr),
        .c0_bvalid(c0_bvalid), .c0_bready(c0_bready),
        .c0_bcid(c0_bcid), .c0_bresp(c0_bresp),
        .c0_rvalid(c0_rvalid), .c0_rready(c0_rready),
        .c0_rcid(c0_rcid), .c0_rdata(c0_rdata), .c0_rresp(c0_rresp),
        .c1_awvalid(c1_awvalid), .c1_awready(c1_awready),
        .c1_awcid(c1_awcid), .c1_awaddr(c1_awaddr),
        .c1_awdata(c1_awdata), .c1_awstrb(c1_awstrb),
        .c1_arvalid(c1_arvalid), .c1_arready(c1_arready),
        .c1_arcid(c1_arcid), .c1_araddr(c1_araddr),
        .c1_bvalid(c1_bvalid), .c1_bready(c1_bready),
        .c1_bcid(c1_bcid), .c1_bresp(c1_bresp),
        .c1_rvalid(c1_rvalid), .c1_rready(c1_rready),
        .c1_rcid(c1_rcid), .c1_rdata(c1_rdata), .c1_rresp(c1_rresp),
        .biu_awcid(biu_awcid), .biu_awaddr(biu_awaddr),
        .biu_awdata(biu_awdata), .biu_awstrb(biu_awstrb),
        .biu_awvalid(biu_awvalid), .biu_awpop(biu_awpop),
        .biu_bcid(biu_bcid), .biu_bresp(biu_bresp),
        .biu_bready(biu_bready), .biu_bpush(biu_bpush),
        .biu_arcid(biu_arcid), .biu_araddr(biu_araddr),
        .biu_arvalid(biu_arvalid), .biu_arpop(biu_arpop),
        .biu_rcid(biu_rcid), .biu_rdata(biu_rdata), .biu_rresp(biu_rresp),
        .biu_rready(biu_rready), .biu_rpush(biu_rpush)
    );

    typedef struct packed {
        logic [CW-1:0] cid;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } awe_t;

    typedef struct packed {
        logic [CW-1:0] cid;
        logic [AW-1:0] addr;
    } are_t;

    // Reference model state.
    awe_t          awq[$];
    are_t          arq[$];
    bit            wp, rp;
    bit            bv, rv;
    logic [CW-1:0] bcid_m, rcid_m;
    logic [1:0]    bresp_m, rresp_m;
    logic [DW-1:0] rdata_m;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Which client wins: -1 none, else client index.
    function automatic int pick(bit v0, bit v1, bit ptr, int cnt);
        if (cnt >= 4 || !(v0 || v1)) return -1;
        if (v0 && v1) return ptr ? 1 : 0;
        return v1 ? 1 : 0;
    endfunction

    task automatic model_clear();
        awq.delete();
        arq.delete();
        wp = 0; rp = 0; bv = 0; rv = 0;
        bcid_m = '0; rcid_m = '0; bresp_m = '0; rresp_m = '0; rdata_m = '0;
    endtask

    task automatic idle();
        c0_awvalid = 0; c1_awvalid = 0; c0_arvalid = 0; c1_arvalid = 0;
        c0_awcid = '0; c1_awcid = '0; c0_awaddr = '0; c1_awaddr = '0;
        c0_awdata = '0; c1_awdata = '0; c0_awstrb = '0; c1_awstrb = '0;
        c0_arcid = '0; c1_arcid = '0; c0_araddr = '0; c1_araddr = '0;
        c0_bready = 1; c1_bready = 1; c0_rready = 1; c1_rready = 1;
        biu_awpop = 0; biu_arpop = 0; biu_bpush = 0; biu_rpush = 0;
        biu_bcid = '0; biu_bresp = '0; biu_rcid = '0;
        biu_rdata = '0; biu_rresp = '0;
    endtask

    task automatic check_outputs();
        int  ga, gr;
        bit  bsr, rsr;
        ga = pick(c0_awvalid, c1_awvalid, wp, awq.size());
        gr = pick(c0_arvalid, c1_arvalid, rp, arq.size());
        chk("c0_awready", c0_awready, ga == 0);
        chk("c1_awready", c1_awready, ga == 1);
        chk("c0_arready", c0_arready, gr == 0);
        chk("c1_arready", c1_arready, gr == 1);
        chk("biu_awvalid", biu_awvalid, awq.size() != 0);
        if (awq.size() != 0) begin
            chk("biu_awcid", biu_awcid, awq[0].cid);
            chk("biu_awaddr", biu_awaddr, awq[0].addr);
            chk("biu_awdata", biu_awdata, awq[0].data);
            chk("biu_awstrb", biu_awstrb, awq[0].strb);
        end
        chk("biu_arvalid", biu_arvalid, arq.size() != 0);
        if (arq.size() != 0) begin
            chk("biu_arcid", biu_arcid, arq[0].cid);
            chk("biu_araddr", biu_araddr, arq[0].addr);
        end
        chk("c0_bvalid", c0_bvalid, bv && !bcid_m[CW-1]);
        chk("c1_bvalid", c1_bvalid, bv && bcid_m[CW-1]);
        if (bv) begin
            chk("bcid", bcid_m[CW-1] ? c1_bcid : c0_bcid, bcid_m[LW-1:0]);
            chk("bresp", bcid_m[CW-1] ? c1_bresp : c0_bresp, bresp_m);
        end
        bsr = bcid_m[CW-1] ? c1_bready : c0_bready;
        chk("biu_bready", biu_bready, !bv || bsr);
        chk("c0_rvalid", c0_rvalid, rv && !rcid_m[CW-1]);
        chk("c1_rvalid", c1_rvalid, rv && rcid_m[CW-1]);
        if (rv) begin
            chk("rcid", rcid_m[CW-1] ? c1_rcid : c0_rcid, rcid_m[LW-1:0]);
            chk("rdata", rcid_m[CW-1] ? c1_rdata : c0_rdata, rdata_m);
            chk("rresp", rcid_m[CW-1] ? c1_rresp : c0_rresp, rresp_m);
        end
        rsr = rcid_m[CW-1] ? c1_rready : c0_rready;
        chk("biu_rready", biu_rready, !rv || rsr);
    endtask

    // Check the current cycle, cross one clock edge, advance the model.
    task automatic step();
        int   ga, gr;
        bit   bsr, rsr, b_acc, r_acc, b_hs, r_hs, awp, arp;
        awe_t we;
        are_t re;
        #1;
        check_outputs();
        ga  = pick(c0_awvalid, c1_awvalid, wp, awq.size());
        gr  = pick(c0_arvalid, c1_arvalid, rp, arq.size());
        awp = biu_awpop && awq.size() != 0;
        arp = biu_arpop && arq.size() != 0;
        bsr = bcid_m[CW-1] ? c1_bready : c0_bready;
        rsr = rcid_m[CW-1] ? c1_rready : c0_rready;
        b_acc = biu_bpush && (!bv || bsr);
        r_acc = biu_rpush && (!rv || rsr);
        b_hs  = bv && bsr;
        r_hs  = rv && rsr;
        if (ga == 1)
            we = '{cid: {1'b1, c1_awcid}, addr: c1_awaddr,
                   data: c1_awdata, strb: c1_awstrb};
        else
            we = '{cid: {1'b0, c0_awcid}, addr: c0_awaddr,
                   data: c0_awdata, strb: c0_awstrb};
        if (gr == 1) re = '{cid: {1'b1, c1_arcid}, addr: c1_araddr};
        else         re = '{cid: {1'b0, c0_arcid}, addr: c0_araddr};
        if (b_acc) begin
            bcid_m = biu_bcid; bresp_m = biu_bresp;
        end
        if (r_acc) begin
            rcid_m = biu_rcid; rdata_m = biu_rdata; rresp_m = biu_rresp;
        end
        @(posedge clk);
        if (awp) void'(awq.pop_front());
        if (arp) void'(arq.pop_front());
        if (ga >= 0) begin
            awq.push_back(we);
            wp = (ga == 0);
        end
        if (gr >= 0) begin
            arq.push_back(re);
            rp = (gr == 0);
        end
        if (b_acc)     bv = 1;
        else if (b_hs) bv = 0;
        if (r_acc)     rv = 1;
        else if (r_hs) rv = 0;
        #1;
    endtask

    // Asynchronous reset from mid-cycle; outputs must drop at once.
    task automatic do_reset();
        #2;
        nrst = 0;
        #1;
        chk("rst_awvalid", biu_awvalid, 0);
        chk("rst_arvalid", biu_arvalid, 0);
        chk("rst_vld", {c0_bvalid, c1_bvalid, c0_rvalid, c1_rvalid}, 0);
        chk("rst_bready", biu_bready, 1);
        chk("rst_rready", biu_rready, 1);
        chk("rst_awcid", biu_awcid, 0);
        chk("rst_araddr", biu_araddr, 0);
        chk("rst_rdata", c0_rdata, 0);
        chk("rst_bcid", c1_bcid, 0);
        model_clear();
        idle();
        repeat (2) @(negedge clk);
        nrst = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst = 0;
        idle();
        model_clear();
        do_reset();
        step();

        // Single write, then its response back to c0.
        c0_awvalid = 1; c0_awcid = 7'h7e; c0_awaddr = 32'h0000_000c;
        c0_awdata = 32'hfefe_fafa; c0_awstrb = 4'hf;
        step();
        c0_awvalid = 0;
        #1;
        chk("t1_awcid", biu_awcid, 8'h7e);
        chk("t1_awdata", biu_awdata, 32'hfefe_fafa);
        biu_awpop = 1;
        step();
        biu_awpop = 0;
        biu_bpush = 1; biu_bcid = 8'h7e; biu_bresp = 2'b00;
        step();
        biu_bpush = 0;
        #1;
        chk("t1_c0_bvalid", c0_bvalid, 1);
        chk("t1_c1_bvalid", c1_bvalid, 0);
        chk("t1_c0_bcid", c0_bcid, 7'h7e);
        step();

        // Read contention with a pop every cycle.
        biu_arpop = 1;
        for (int i = 0; i < 5; i++) begin
            c0_arvalid = 1; c1_arvalid = 1;
            c0_arcid = 7'($urandom); c1_arcid = 7'($urandom);
            c0_araddr = $urandom; c1_araddr = $urandom;
            step();
            #1;
            chk("cont_msb", biu_arcid[CW-1], i % 2);
        end
        c0_arvalid = 0; c1_arvalid = 0;
        step();
        biu_arpop = 0;

        // Fill the read FIFO from c1.
        c1_arvalid = 1;
        for (int i = 0; i < 4; i++) begin
            c1_arcid = 7'(i); c1_araddr = 32'h100 + 32'(i);
            step();
        end
        c1_araddr = 32'h200;
        #1;
        chk("full_arready", c1_arready, 0);
        step();
        biu_arpop = 1;
        #1;
        chk("full_pop_rdy", c1_arready, 0);
        step();
        biu_arpop = 0;
        #1;
        chk("after_pop_rdy", c1_arready, 1);
        step();
        c1_arvalid = 0;

        // Read response backpressure on c1.
        c1_rready = 0;
        biu_rpush = 1; biu_rcid = 8'h85; biu_rdata = 32'hdede_dada;
        step();
        #1;
        chk("bp_c1_rvalid", c1_rvalid, 1);
        chk("bp_biu_rready", biu_rready, 0);
        biu_rcid = 8'h81; biu_rdata = 32'h1111_2222;
        step();
        biu_rpush = 0;
        #1;
        chk("bp_drop_data", c1_rdata, 32'hdede_dada);
        chk("bp_drop_cid", c1_rcid, 7'h05);
        c1_rready = 1;
        #1;
        chk("bp_rready_up", biu_rready, 1);
        step();
        #1;
        chk("bp_hs_done", c1_rvalid, 0);

        // Underflow pop on the empty write FIFO.
        biu_awpop = 1;
        step();
        biu_awpop = 0;
        #1;
        chk("uf_awvalid", biu_awvalid, 0);
        step();

        // Held response plus queued reads, then reset.
        c0_rready = 0;
        biu_rpush = 1; biu_rcid = 8'h05; biu_rdata = 32'h5a5a_0000;
        step();
        biu_rpush = 0;
        #1;
        chk("pre_rst_q", arq.size() >= 3, 1);
        do_reset();
        chk("post_rst_ar", biu_arvalid, 0);
        step();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            c0_awvalid = 1'($urandom); c1_awvalid = 1'($urandom);
            c0_arvalid = 1'($urandom); c1_arvalid = 1'($urandom);
            c0_awcid = 7'($urandom); c1_awcid = 7'($urandom);
            c0_awaddr = $urandom; c1_awaddr = $urandom;
            c0_awdata = $urandom; c1_awdata = $urandom;
            c0_awstrb = 4'($urandom); c1_awstrb = 4'($urandom);
            c0_arcid = 7'($urandom); c1_arcid = 7'($urandom);
            c0_araddr = $urandom; c1_araddr = $urandom;
            c0_bready = ($urandom_range(0, 9) < 7);
            c1_bready = ($urandom_range(0, 9) < 7);
            c0_rready = ($urandom_range(0, 9) < 7);
            c1_rready = ($urandom_range(0, 9) < 7);
            biu_awpop = ($urandom_range(0, 9) < 4);
            biu_arpop = ($urandom_range(0, 9) < 4);
            biu_bpush = 1'($urandom); biu_bcid = 8'($urandom);
            biu_bresp = 2'($urandom);
            biu_rpush = 1'($urandom); biu_rcid = 8'($urandom);
            biu_rdata = $urandom; biu_rresp = 2'($urandom);
            step();
            if (n == 1500) do_reset();
        end
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
